// File: rtl/wb_writeback_unit_pkg.sv
// Shared types and constants for the writeback unit.
// Widths, source-select encoding, divider buffer entry.
package wb_writeback_unit_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        SRC_ALU,
        SRC_MEM,
        SRC_LINK
    } wb_src_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] index;
        logic [DATA_W-1:0] data;
    } buf_entry_t;

    // Link outranks load data, which outranks the ALU result.
    function automatic wb_src_e wb_src_sel(input logic link,
                                           input logic memtoreg);
        if (link)
            return SRC_LINK;
        if (memtoreg)
            return SRC_MEM;
        return SRC_ALU;
    endfunction

endpackage

// File: rtl/wb_writeback_unit_if.sv
// Divider result handshake into the writeback unit.
// master: divider (valid/writereg/result), slave: writeback unit (ready).
interface wb_writeback_unit_if;
    import wb_writeback_unit_pkg::*;

    logic              div_valid;
    logic              div_ready;
    logic [ADDR_W-1:0] div_writereg;
    logic [DATA_W-1:0] div_result;

    modport master (
        output div_valid,
        output div_writereg,
        output div_result,
        input  div_ready
    );

    modport slave (
        input  div_valid,
        input  div_writereg,
        input  div_result,
        output div_ready
    );

endinterface

// File: rtl/wb_div_buffer.sv
// Divider result FIFO with squash and pending-index lookups.
// Ports: push/pop, squash index, two lookup indices; full/empty/head/hits.
module wb_div_buffer
    import wb_writeback_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_index,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              squash,
    input  logic [ADDR_W-1:0] squash_index,
    input  logic [ADDR_W-1:0] look1,
    input  logic [ADDR_W-1:0] look2,
    output logic              full,
    output logic              empty,
    output buf_entry_t        head,
    output logic              hit1,
    output logic              hit2
);

    localparam int CW = $clog2(DEPTH + 1);

    // Entries are kept compacted: the head pointer is always slot 0
    // and the tail pointer equals count. A squash closes the hole in
    // the same cycle, so squashed slots never reach the head.
    buf_entry_t    ent     [DEPTH];
    buf_entry_t    ent_nxt [DEPTH];
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    always_comb begin : compact
        int n;
        n = 0;
        for (int j = 0; j < DEPTH; j++)
            ent_nxt[j] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent[i].valid
                && !(pop && i == 0)
                && !(squash && ent[i].index == squash_index)) begin
                for (int j = 0; j < DEPTH; j++)
                    if (j == n)
                        ent_nxt[j] = ent[i];
                n++;
            end
        end
        if (push && !(squash && push_index == squash_index)) begin
            for (int j = 0; j < DEPTH; j++)
                if (j == n)
                    ent_nxt[j] = '{valid: 1'b1,
                                   index: push_index,
                                   data:  push_data};
            n++;
        end
        count_nxt = CW'(n);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                ent[i] <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                ent[i] <= ent_nxt[i];
            count <= count_nxt;
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = ent[0];

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent[i].valid && ent[i].index == look1)
                hit1 = 1'b1;
            if (ent[i].valid && ent[i].index == look2)
                hit2 = 1'b1;
        end
    end

endmodule

// File: rtl/wb_writeback_unit.sv
// Register file write port arbiter: MEM/WB results first, buffered
// divider results otherwise. Also drives decode bypass/pending flags.
module wb_writeback_unit
    import wb_writeback_unit_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memwb_valid,
    input  logic              memwb_regwrite,
    input  logic              memwb_memtoreg,
    input  logic              memwb_link,
    input  logic [ADDR_W-1:0] memwb_writereg,
    input  logic [DATA_W-1:0] memwb_aluresult,
    input  logic [DATA_W-1:0] memwb_readdata,
    input  logic [DATA_W-1:0] memwb_pc8,
    wb_writeback_unit_if.slave div_bus,
    output logic [ADDR_W-1:0] writereg,
    output logic [DATA_W-1:0] writeda,
    output logic              regwrite,
    input  logic [ADDR_W-1:0] readreg1,
    input  logic [ADDR_W-1:0] readreg2,
    output logic              bypass1,
    output logic              bypass2,
    output logic              pend1,
    output logic              pend2
);

    logic              wr_pipe;
    logic [DATA_W-1:0] pipe_data;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              hit1;
    logic              hit2;
    buf_entry_t        head;

    assign wr_pipe = memwb_valid & memwb_regwrite
                   & (memwb_writereg != REG_ZERO);

    always_comb begin
        unique case (wb_src_sel(memwb_link, memwb_memtoreg))
            SRC_LINK: pipe_data = memwb_pc8;
            SRC_MEM:  pipe_data = memwb_readdata;
            default:  pipe_data = memwb_aluresult;
        endcase
    end

    // Ready depends only on occupancy, never on a same-cycle pop.
    assign div_bus.div_ready = rst_n & ~full;

    // r0 results complete the handshake but are dropped here.
    assign push = div_bus.div_valid & div_bus.div_ready
                & (div_bus.div_writereg != REG_ZERO);

    assign pop = ~wr_pipe & ~empty & head.valid;

    wb_div_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .push_index   (div_bus.div_writereg),
        .push_data    (div_bus.div_result),
        .pop          (pop),
        .squash       (wr_pipe),
        .squash_index (memwb_writereg),
        .look1        (readreg1),
        .look2        (readreg2),
        .full         (full),
        .empty        (empty),
        .head         (head),
        .hit1         (hit1),
        .hit2         (hit2)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            writereg <= '0;
            writeda  <= '0;
            regwrite <= 1'b0;
        end else if (wr_pipe) begin
            writereg <= memwb_writereg;
            writeda  <= pipe_data;
            regwrite <= 1'b1;
        end else if (pop) begin
            writereg <= head.index;
            writeda  <= head.data;
            regwrite <= 1'b1;
        end else begin
            regwrite <= 1'b0;
        end
    end

    assign bypass1 = regwrite & (writereg == readreg1)
                   & (readreg1 != REG_ZERO);
    assign bypass2 = regwrite & (writereg == readreg2)
                   & (readreg2 != REG_ZERO);

    assign pend1 = hit1 & (readreg1 != REG_ZERO);
    assign pend2 = hit2 & (readreg2 != REG_ZERO);

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Scoreboard bench for wb_writeback_unit.
// Expected register writes are queued at stimulus time, popped on regwrite.
module tb_wb_writeback_unit;
    import wb_writeback_unit_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              memwb_valid;
    logic              memwb_regwrite;
    logic              memwb_memtoreg;
    logic              memwb_link;
    logic [ADDR_W-1:0] memwb_writereg;
    logic [DATA_W-1:0] memwb_aluresult;
    logic [DATA_W-1:0] memwb_readdata;
    logic [DATA_W-1:0] memwb_pc8;
    logic [ADDR_W-1:0] writereg;
    logic [DATA_W-1:0] writeda;
    logic              regwrite;
    logic [ADDR_W-1:0] readreg1;
    logic [ADDR_W-1:0] readreg2;
    logic              bypass1;
    logic              bypass2;
    logic              pend1;
    logic              pend2;

    wb_writeback_unit_if dbus ();

    wb_writeback_unit #(
        .BUF_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .memwb_valid     (memwb_valid),
        .memwb_regwrite  (memwb_regwrite),
        .memwb_memtoreg  (memwb_memtoreg),
        .memwb_link      (memwb_link),
        .memwb_writereg  (memwb_writereg),
        .memwb_aluresult (memwb_aluresult),
        .memwb_readdata  (memwb_readdata),
        .memwb_pc8       (memwb_pc8),
        .div_bus         (dbus),
        .writereg        (writereg),
        .writeda         (writeda),
        .regwrite        (regwrite),
        .readreg1        (readreg1),
        .readreg2        (readreg2),
        .bypass1         (bypass1),
        .bypass2         (bypass2),
        .pend1           (pend1),
        .pend2           (pend2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        memwb_valid     = 1'b0;
        memwb_regwrite  = 1'b0;
        memwb_memtoreg  = 1'b0;
        memwb_link      = 1'b0;
        memwb_writereg  = '0;
        memwb_aluresult = '0;
        memwb_readdata  = '0;
        memwb_pc8       = '0;
    endtask

    task automatic exp_push(input logic [ADDR_W-1:0] r,
                            input logic [DATA_W-1:0] d);
        exp_t e;
        e.idx  = r;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic pipe(input logic [ADDR_W-1:0] r,
                        input logic [DATA_W-1:0] alu,
                        input logic [DATA_W-1:0] rd,
                        input logic [DATA_W-1:0] pc8,
                        input logic m,
                        input logic l);
        memwb_valid     = 1'b1;
        memwb_regwrite  = 1'b1;
        memwb_memtoreg  = m;
        memwb_link      = l;
        memwb_writereg  = r;
        memwb_aluresult = alu;
        memwb_readdata  = rd;
        memwb_pc8       = pc8;
        if (r != 0)
            exp_push(r, l ? pc8 : (m ? rd : alu));
    endtask

    task automatic div_drive(input logic v,
                             input logic [ADDR_W-1:0] r,
                             input logic [DATA_W-1:0] d);
        dbus.div_valid    = v;
        dbus.div_writereg = r;
        dbus.div_result   = d;
    endtask

    // Every register write must match the oldest expected write.
    always @(negedge clk) begin
        if (regwrite === 1'b1) begin
            chk("r0_write", 32'(writereg != 0), 1);
            if (sb.size() == 0) begin
                chk("spurious_write", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_index", 32'(writereg), 32'(mon_e.idx));
                chk("wr_data", writeda, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout, no finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        idle();
        div_drive(1'b1, 5'd9, 32'd7);
        readreg1 = '0;
        readreg2 = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_regwrite", 32'(regwrite), 0);
        chk("rst_writereg", 32'(writereg), 0);
        chk("rst_writeda", writeda, 0);
        chk("rst_div_ready", 32'(dbus.div_ready), 0);

        tick();
        rst_n    = 1'b1;
        div_drive(1'b0, '0, '0);
        readreg1 = 5'd9;
        tick();
        @(negedge clk);
        chk("post_rst_pend1", 32'(pend1), 0);
        chk("post_rst_ready", 32'(dbus.div_ready), 1);

        // Pipeline writes: ALU, load, link-overrides-load.
        tick(); pipe(5'd3, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        tick(); pipe(5'd4, 32'd1, 32'd8, 32'd0, 1'b1, 1'b0);
        tick(); pipe(5'd2, 32'd1, 32'd8, 32'h40, 1'b1, 1'b1);
        tick();
        idle();
        readreg1 = 5'd2;
        readreg2 = 5'd5;
        @(negedge clk);
        chk("byp_regwrite", 32'(regwrite), 1);
        chk("bypass1", 32'(bypass1), 1);
        chk("bypass2", 32'(bypass2), 0);
        chk("byp_data", writeda, 32'h40);

        // r0 from the pipeline.
        tick();
        pipe(5'd0, 32'h55, 32'd0, 32'd0, 1'b0, 1'b0);
        readreg1 = 5'd0;
        tick();
        idle();
        @(negedge clk);
        chk("r0_pipe_regwrite", 32'(regwrite), 0);
        chk("r0_bypass1", 32'(bypass1), 0);
        chk("r0_pend1", 32'(pend1), 0);

        // r0 from the divider: accepted, never written.
        tick();
        div_drive(1'b1, 5'd0, 32'h77);
        @(negedge clk);
        chk("div_r0_ready", 32'(dbus.div_ready), 1);
        tick();
        div_drive(1'b0, '0, '0);
        tick();
        @(negedge clk);
        chk("div_r0_nowrite", 32'(regwrite), 0);

        // Divider results queued behind a pipeline burst.
        readreg1 = 5'd6;
        readreg2 = 5'd7;
        tick();
        pipe(5'd1, 32'h10, 32'd0, 32'd0, 1'b0, 1'b0);
        div_drive(1'b1, 5'd6, 32'd2);
        @(negedge clk);
        chk("burst_rdy0", 32'(dbus.div_ready), 1);
        tick();
        pipe(5'd1, 32'h11, 32'd0, 32'd0, 1'b0, 1'b0);
        div_drive(1'b1, 5'd7, 32'd4);
        @(negedge clk);
        chk("burst_rdy1", 32'(dbus.div_ready), 1);
        tick();
        pipe(5'd1, 32'h12, 32'd0, 32'd0, 1'b0, 1'b0);
        div_drive(1'b1, 5'd8, 32'd6);
        @(negedge clk);
        chk("third_offer_rdy", 32'(dbus.div_ready), 0);
        tick();
        pipe(5'd1, 32'h13, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_rdy", 32'(dbus.div_ready), 0);
        chk("burst_pend1", 32'(pend1), 1);
        chk("burst_pend2", 32'(pend2), 1);
        tick();
        idle();
        exp_push(5'd6, 32'd2);
        exp_push(5'd7, 32'd4);
        exp_push(5'd8, 32'd6);
        @(negedge clk);
        chk("full_pop_rdy", 32'(dbus.div_ready), 0);
        tick();
        @(negedge clk);
        chk("div1_regwrite", 32'(regwrite), 1);
        chk("div1_index", 32'(writereg), 6);
        chk("div1_rdy", 32'(dbus.div_ready), 1);
        tick();
        div_drive(1'b0, '0, '0);
        @(negedge clk);
        chk("div2_regwrite", 32'(regwrite), 1);
        chk("div2_index", 32'(writereg), 7);
        tick();
        @(negedge clk);
        chk("div3_regwrite", 32'(regwrite), 1);
        chk("div3_index", 32'(writereg), 8);
        tick();
        @(negedge clk);
        chk("drain_idle", 32'(regwrite), 0);

        // Squash of a buffered entry by a younger pipeline write.
        readreg1 = 5'd15;
        tick();
        div_drive(1'b1, 5'd15, 32'd1);
        @(negedge clk);
        chk("sq_rdy", 32'(dbus.div_ready), 1);
        tick();
        div_drive(1'b0, '0, '0);
        pipe(5'd15, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("sq_pend_before", 32'(pend1), 1);
        tick();
        idle();
        @(negedge clk);
        chk("sq_pend_after", 32'(pend1), 0);
        chk("sq_data", writeda, 32'd9);
        tick();
        @(negedge clk);
        chk("sq_dropped", 32'(regwrite), 0);
        chk("sq_rdy_after", 32'(dbus.div_ready), 1);

        // Same-cycle push is squashed too.
        readreg1 = 5'd20;
        tick();
        pipe(5'd20, 32'd11, 32'd0, 32'd0, 1'b0, 1'b0);
        div_drive(1'b1, 5'd20, 32'd3);
        @(negedge clk);
        chk("sq2_rdy", 32'(dbus.div_ready), 1);
        tick();
        idle();
        div_drive(1'b0, '0, '0);
        @(negedge clk);
        chk("sq2_pend", 32'(pend1), 0);
        tick();
        @(negedge clk);
        chk("sq2_dropped", 32'(regwrite), 0);

        // Reset mid-operation drops buffered results.
        readreg1 = 5'd9;
        tick();
        pipe(5'd1, 32'h21, 32'd0, 32'd0, 1'b0, 1'b0);
        div_drive(1'b1, 5'd9, 32'h99);
        tick();
        idle();
        div_drive(1'b0, '0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_pend_before", 32'(pend1), 1);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_regwrite", 32'(regwrite), 0);
        chk("mr_pend_after", 32'(pend1), 0);
        repeat (2) tick();
        @(negedge clk);
        chk("mr_nowrite", 32'(regwrite), 0);

        chk("sb_left", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule
